inst_axi_rd_bridge: RTL and testbench
=====================================

// Module: inst_axi_rd_bridge
// PURPOSE
//  Converts the fetch stage's SRAM-like instruction port (req/addr_ok/data_ok) into an AXI4 read-only master.
//  Sits directly upstream of the fetch stage, between its inst_sram_* port and the AXI crossbar.
//  Carries up to MAX_OUTST in-order reads.
//  Returns exactly one data_ok per accepted address, in acceptance order.
// PARAMETERS
//  MAX_OUTST  2    max accepted-but-unreturned reads (1..15)
//  ARID_VAL   4'h0 constant ARID for all fetch reads
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-high reset
//  inst_sram_req  in   1   read request; held by master until addr_ok
//  inst_sram_wr   in   1   must be 0; a request with wr=1 is never accepted
//  inst_sram_size in   2   log2 bytes (2'b10 = word)
//  inst_sram_addr in   32  byte address
//  inst_sram_addr_ok out 1 address accepted this cycle
//  inst_sram_data_ok out 1 one-cycle pulse: rdata valid
//  inst_sram_rdata out 32  instruction word; valid only with data_ok
//  arid     out 4   = ARID_VAL
//  araddr   out 32  latched request address
//  arlen    out 8   = 0 (single beat)
//  arsize   out 3   = {1'b0, latched size}
//  arburst  out 2   = 2'b01
//  arlock/arcache/arprot  out 2/4/3  = 0
//  arvalid  out 1   AR valid
//  arready  in  1   AR ready
//  rid      in  4   ignored (single ID, in-order)
//  rdata    in  32  read data
//  rresp    in  2   ignored; data is forwarded unchanged
//  rlast    in  1   ignored (arlen = 0)
//  rvalid   in  1   R valid
//  rready   out 1   constant 1 after reset
// BEHAVIOUR
//  Reset values:
//   - addr_ok=0, data_ok=0, rdata=0, arvalid=0, araddr=0, rready=0.
//   - outst_cnt=0; AR FSM in AR_IDLE.
//  AR FSM: AR_IDLE, AR_SEND.
//   - addr_ok = req & ~wr & AR_IDLE & (outst_cnt < MAX_OUTST). It is combinational.
//   - On addr_ok: latch addr/size, go to AR_SEND. arvalid=1 from the next cycle.
//   - AR_SEND: hold arvalid and araddr stable until arvalid & arready, then return to AR_IDLE.
//   - No new addr_ok while in AR_SEND, including the handshake cycle. Max one AR accept per 2 cycles.
//  R path:
//   - rready=1 every cycle after reset.
//   - On rvalid & rready: register rdata into inst_sram_rdata and set data_ok=1 the next cycle, for 1 cycle.
//   - Min latency: addr_ok in cycle N, arvalid in N+1, earliest R beat N+2, data_ok N+3.
//  outst_cnt (4 bits):
//   - +1 on addr_ok; -1 on the data_ok pulse.
//   - Both in the same cycle: unchanged.
//   - Saturated at MAX_OUTST: addr_ok is held low. The held req stays pending, with no loss.
//   - data_ok with outst_cnt=0 is illegal (slave error). Assert in simulation; the counter does not underflow.
//  Ordering: data returned strictly in AR order. The fetch stage discards stale (cancelled) returns itself by counting.
//  wr=1: never accepted, never issues AR. The requester stalls; no error is raised.
//  Reset mid-operation:
//   - All state is cleared and in-flight AXI reads are forgotten.
//   - The AXI slave is reset by the same reset.
// TESTING
//  T1 single fetch: req addr=1c000000 cycle 0, arready=1, rvalid cycle 2 rdata=02c00000 -> addr_ok@0, araddr=1c000000@1, data_ok@3 rdata=02c00000.
//  T2 arready backpressure: arready low 5 cycles -> arvalid/araddr stable 5 cycles, addr_ok low until AR_IDLE, no duplicate AR.
//  T3 saturation MAX_OUTST=2: 3 back-to-back reqs, R delayed 10 cycles -> 2 ARs issued, 3rd addr_ok only after first data_ok, 3 data_ok in order.
//  T4 simultaneous: addr_ok and data_ok same cycle at outst_cnt=1 -> count stays 1, next req accepted immediately.
//  T5 reset mid-flight: reset with 2 outstanding and arvalid=1 -> next cycle all outputs at reset values, count 0, fresh fetch works.
//  T6 wr=1 req held 8 cycles -> addr_ok and arvalid stay 0.

Source files
------------

// File: rtl/inst_axi_rd_bridge_if.sv
// Bus bundles for inst_axi_rd_bridge.
//   inst_sram_if : fetch-stage SRAM-like instruction port (req/addr_ok/data_ok).
//                  master = fetch stage, slave = bridge.
//   axi_rd_if    : AXI4 read-address and read-data channels.
//                  master = bridge, slave = crossbar / memory.
// Signal names keep the fetch-stage and AXI names so waveforms line up with
// the surrounding pipeline.

interface inst_sram_if;
    logic        inst_sram_req;
    logic        inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        input  inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );

    modport slave (
        input  inst_sram_req, inst_sram_wr, inst_sram_size, inst_sram_addr,
        output inst_sram_addr_ok, inst_sram_data_ok, inst_sram_rdata
    );
endinterface

interface axi_rd_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
               arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/inst_axi_rd_bridge.sv
// inst_axi_rd_bridge
//   Turns the fetch stage's SRAM-like instruction port into a single-ID,
//   single-beat AXI4 read master. Up to MAX_OUTST reads may be accepted but
//   not yet returned; data comes back strictly in acceptance order, one
//   data_ok pulse per accepted address.
// Ports
//   clk   : clock
//   reset : synchronous, active-high reset; clears all state, in-flight reads
//           are forgotten (the AXI slave shares this reset)
//   sram  : inst_sram_if.slave  - req/wr/size/addr in, addr_ok/data_ok/rdata out
//   axi   : axi_rd_if.master    - AR channel out, R channel in (rready out)
// Parameters
//   MAX_OUTST : max accepted-but-unreturned reads (1..15)
//   ARID_VAL  : constant ARID driven on every read

module inst_axi_rd_bridge #(
    parameter int         MAX_OUTST = 2,
    parameter logic [3:0] ARID_VAL  = 4'h0
) (
    input  logic       clk,
    input  logic       reset,
    inst_sram_if.slave sram,
    axi_rd_if.master   axi
);

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTST);

    typedef enum logic {
        AR_IDLE = 1'b0,
        AR_SEND = 1'b1
    } ar_state_t;

    ar_state_t   ar_state;
    ar_state_t   ar_state_nxt;
    logic        addr_ok;
    logic [3:0]  outst_cnt;
    logic [31:0] araddr_q;
    logic [1:0]  arsize_q;
    logic        rready_q;
    logic        data_ok_q;
    logic [31:0] rdata_q;
    logic        cnt_inc;
    logic        cnt_dec;

    // ------------------------------------------------------------------
    // AR channel FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) ar_state <= AR_IDLE;
        else       ar_state <= ar_state_nxt;
    end

    // addr_ok is only possible from AR_IDLE, so the AR handshake cycle never
    // accepts a new address: at most one accept every two cycles.
    always_comb begin
        ar_state_nxt = ar_state;
        addr_ok      = 1'b0;
        case (ar_state)
            AR_IDLE: begin
                addr_ok = sram.inst_sram_req & ~sram.inst_sram_wr &
                          (outst_cnt < MAX_CNT);
                if (addr_ok) ar_state_nxt = AR_SEND;
            end
            AR_SEND: begin
                if (axi.arready) ar_state_nxt = AR_IDLE;
            end
            default: ar_state_nxt = AR_IDLE;
        endcase
    end

    // Address/size latched on accept and held until the AR handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            araddr_q <= 32'h0;
            arsize_q <= 2'b00;
        end else if (addr_ok) begin
            araddr_q <= sram.inst_sram_addr;
            arsize_q <= sram.inst_sram_size;
        end
    end

    // ------------------------------------------------------------------
    // R channel: always ready, data registered, one-cycle data_ok
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rready_q  <= 1'b0;
            data_ok_q <= 1'b0;
            rdata_q   <= 32'h0;
        end else begin
            rready_q  <= 1'b1;
            data_ok_q <= axi.rvalid & rready_q;
            if (axi.rvalid & rready_q) rdata_q <= axi.rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outstanding-read counter
    // ------------------------------------------------------------------
    // A data_ok with nothing outstanding is a slave fault; the counter holds
    // at zero rather than wrapping.
    assign cnt_inc = addr_ok;
    assign cnt_dec = data_ok_q & (outst_cnt != 4'd0);

    always_ff @(posedge clk) begin
        if (reset) begin
            outst_cnt <= 4'd0;
        end else begin
            case ({cnt_inc, cnt_dec})
                2'b10:   outst_cnt <= outst_cnt + 4'd1;
                2'b01:   outst_cnt <= outst_cnt - 4'd1;
                default: outst_cnt <= outst_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            a_no_spurious_data : assert (!(data_ok_q && outst_cnt == 4'd0));
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign sram.inst_sram_addr_ok = addr_ok;
    assign sram.inst_sram_data_ok = data_ok_q;
    assign sram.inst_sram_rdata   = rdata_q;

    assign axi.arid    = ARID_VAL;
    assign axi.araddr  = araddr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = {1'b0, arsize_q};
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'b0000;
    assign axi.arprot  = 3'b000;
    assign axi.arvalid = (ar_state == AR_SEND);
    assign axi.rready  = rready_q;

    // rid/rresp/rlast carry no information for a single-ID, single-beat,
    // forward-unchanged master.
    logic unused_r_fields;
    assign unused_r_fields = ^{axi.rid, axi.rresp, axi.rlast};

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Scoreboard bench for inst_axi_rd_bridge.
//   - Driver tasks issue fetch requests; on each accept the expected rdata and
//     the expected AR address are pushed into queues.
//   - An AXI slave model answers each AR from a small memory table after
//     r_delay cycles and checks the AR address/constant fields.
//   - A monitor pops the expected-data queue on every data_ok.
//   Inputs change 1ns after posedge (slave: on negedge); outputs sampled on negedge.

module tb_inst_axi_rd_bridge;

    logic clk;
    logic reset;
    int   cyc;

    inst_sram_if sram ();
    axi_rd_if    axi ();

    inst_axi_rd_bridge #(.MAX_OUTST(2), .ARID_VAL(4'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .sram  (sram),
        .axi   (axi)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rbeat_t;

    vec_t        vecs [13];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] exp_q [$];
    logic [31:0] exp_ar_q [$];
    rbeat_t      pend_q [$];
    int          r_delay;
    int          ar_hs;
    int          last_dok_cyc;
    int          n_vec;
    int          n_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Present vecs[idx] until addr_ok; returns the accept cycle in c.
    task automatic acc(input int idx, output int c);
        sram.inst_sram_req  = 1'b1;
        sram.inst_sram_wr   = 1'b0;
        sram.inst_sram_size = 2'b10;
        sram.inst_sram_addr = vecs[idx].addr;
        c = -1;
        for (int i = 0; i < 60 && c < 0; i++) begin
            @(negedge clk);
            if (sram.inst_sram_addr_ok) begin
                c = cyc;
                exp_q.push_back(vecs[idx].data);
                exp_ar_q.push_back(vecs[idx].addr);
            end
        end
        chk1($sformatf("accepted_%0d", idx), c >= 0, 1'b1);
        @(posedge clk);
        #1;
        sram.inst_sram_req = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        chk({name, "_drain"}, exp_q.size(), 32'd0);
        chk({name, "_ar_left"}, exp_ar_q.size(), 32'd0);
    endtask

    // ---------------- AXI slave model ----------------
    initial begin
        axi.arready = 1'b1;
        axi.rvalid  = 1'b0;
        axi.rdata   = 32'h0;
        axi.rid     = 4'h0;
        axi.rresp   = 2'b00;
        axi.rlast   = 1'b1;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend_q.delete();
                axi.rvalid = 1'b0;
                axi.rdata  = 32'h0;
            end else begin
                if (axi.arvalid && axi.arready) begin
                    ar_hs++;
                    if (exp_ar_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL ar_unexpected: araddr %h with no accepted request", axi.araddr);
                    end else begin
                        chk("araddr", axi.araddr, exp_ar_q.pop_front());
                    end
                    chk("ar_fields",
                        {6'b0, axi.arid, axi.arlen, axi.arsize, axi.arburst,
                         axi.arlock, axi.arcache, axi.arprot},
                        {6'b0, 4'h0, 8'h00, 3'b010, 2'b01, 2'b00, 4'h0, 3'b000});
                    pend_q.push_back('{data: mem.exists(axi.araddr) ? mem[axi.araddr] : 32'hdeadbeef,
                                       due: cyc + 1 + r_delay});
                end
                if (pend_q.size() != 0 && pend_q[0].due <= cyc && axi.rready) begin
                    axi.rvalid = 1'b1;
                    axi.rdata  = pend_q[0].data;
                    void'(pend_q.pop_front());
                end else begin
                    axi.rvalid = 1'b0;
                    axi.rdata  = 32'h0;
                end
            end
        end
    end

    // ---------------- data_ok monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && sram.inst_sram_data_ok) begin
                last_dok_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL dok_unexpected: rdata %h with nothing outstanding", sram.inst_sram_rdata);
                end else begin
                    chk("rdata", sram.inst_sram_rdata, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int n, c, c1, c2, base;
        n_vec = 0; n_err = 0; ar_hs = 0; last_dok_cyc = -1; r_delay = 0;
        vecs = '{
            '{32'h1c000000, 32'h02c00000},  // T1
            '{32'h1c000004, 32'h0280040c},  // T2 A
            '{32'h1c000008, 32'h15000013},  // T2 B
            '{32'h1c000010, 32'h00c000ff},  // T3
            '{32'h1c000014, 32'h29800004},
            '{32'h1c000018, 32'h4c000020},
            '{32'h1c000020, 32'h02bffc63},  // T4
            '{32'h1c000024, 32'h58000c85},
            '{32'h1c000028, 32'h03400000},
            '{32'h1c000040, 32'h1a000004},  // T5 (lost to reset)
            '{32'h1c000044, 32'h28c00084},
            '{32'h1c000100, 32'h50000800},  // T5 fresh fetch
            '{32'h1c000200, 32'h00000000}   // T6 wr=1, never issued
        };
        foreach (vecs[i]) mem[vecs[i].addr] = vecs[i].data;

        reset = 1'b1;
        sram.inst_sram_req  = 1'b0;
        sram.inst_sram_wr   = 1'b0;
        sram.inst_sram_size = 2'b10;
        sram.inst_sram_addr = 32'h0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs",
            {28'b0, sram.inst_sram_addr_ok, sram.inst_sram_data_ok, axi.arvalid, axi.rready},
            32'h0);
        chk("rst_rdata", sram.inst_sram_rdata, 32'h0);
        chk("rst_araddr", axi.araddr, 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk1("rready_after_reset", axi.rready, 1'b1);
        @(posedge clk); #1;

        // T1 single fetch, minimum latency
        r_delay = 0;
        acc(0, n);
        @(negedge clk);
        chk1("t1_arvalid", axi.arvalid, 1'b1);
        chk("t1_araddr", axi.araddr, 32'h1c000000);
        drain("t1");
        chk("t1_latency", last_dok_cyc - n, 32'd3);
        @(posedge clk); #1;

        // T2 arready backpressure
        r_delay = 2;
        axi.arready = 1'b0;
        acc(1, n);
        sram.inst_sram_req  = 1'b1;
        sram.inst_sram_addr = vecs[2].addr;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk1("t2_arvalid_hold", axi.arvalid, 1'b1);
            chk("t2_araddr_hold", axi.araddr, 32'h1c000004);
            chk1("t2_no_addr_ok", sram.inst_sram_addr_ok, 1'b0);
            @(posedge clk); #1;
        end
        axi.arready = 1'b1;
        @(negedge clk);
        chk1("t2_no_addr_ok_hs", sram.inst_sram_addr_ok, 1'b0);
        @(posedge clk); #1;
        acc(2, c);
        chk("t2_b_accept", c - n, 32'd7);
        drain("t2");
        @(posedge clk); #1;

        // T3 saturation at MAX_OUTST=2
        r_delay = 10;
        base = ar_hs;
        acc(3, n);
        acc(4, c1);
        acc(5, c2);
        chk("t3_second_acc", c1 - n, 32'd2);
        chk("t3_third_acc", c2 - n, 32'd14);
        chk("t3_ar_before_third", ar_hs - base, 32'd2);
        drain("t3");
        @(posedge clk); #1;

        // T4 addr_ok and data_ok in the same cycle at outst_cnt=1
        r_delay = 0;
        acc(6, n);
        @(posedge clk); #1;
        @(posedge clk); #1;
        acc(7, c1);
        @(negedge clk);
        chk("t4_accept_cycle", c1 - n, 32'd3);
        chk("t4_dok_cycle", last_dok_cyc - n, 32'd3);
        chk("t4_cnt", {28'b0, dut.outst_cnt}, 32'd1);
        acc(8, c2);
        chk("t4_next_accept", c2 - n, 32'd5);
        drain("t4");
        @(posedge clk); #1;

        // T5 reset with two reads outstanding and arvalid held
        r_delay = 20;
        acc(9, n);
        acc(10, c);
        axi.arready = 1'b0;
        @(negedge clk);
        chk1("t5_pre_arvalid", axi.arvalid, 1'b1);
        chk("t5_pre_cnt", {28'b0, dut.outst_cnt}, 32'd2);
        @(posedge clk); #1;
        reset = 1'b1;
        exp_q.delete();
        exp_ar_q.delete();
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("t5_outputs",
            {28'b0, sram.inst_sram_addr_ok, sram.inst_sram_data_ok, axi.arvalid, axi.rready},
            32'h0);
        chk("t5_araddr", axi.araddr, 32'h0);
        chk("t5_rdata", sram.inst_sram_rdata, 32'h0);
        chk("t5_cnt", {28'b0, dut.outst_cnt}, 32'd0);
        @(posedge clk); #1;
        axi.arready = 1'b1;
        r_delay = 0;
        acc(11, n);
        drain("t5");
        chk("t5_latency", last_dok_cyc - n, 32'd3);
        @(posedge clk); #1;

        // T6 write request is never accepted
        base = ar_hs;
        sram.inst_sram_req  = 1'b1;
        sram.inst_sram_wr   = 1'b1;
        sram.inst_sram_addr = vecs[12].addr;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk1("t6_addr_ok", sram.inst_sram_addr_ok, 1'b0);
            chk1("t6_arvalid", axi.arvalid, 1'b0);
        end
        @(posedge clk); #1;
        sram.inst_sram_req = 1'b0;
        sram.inst_sram_wr  = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_no_ar", ar_hs - base, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
